// File: rtl/mux_32b_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mux_32b_pkg
// Description : Shared datapath constants for the MIPS word-select unit.
//               Holds the data width and the select encodings used by the
//               2-way and 4-way word multiplexers.
// Revision    : 1.0 - initial release
// ============================================================================
package mux_32b_pkg;

    // Datapath word width.
    localparam int WIDTH = 32;

    // 2-way select encodings.
    localparam logic SEL2_IN0 = 1'b0;
    localparam logic SEL2_IN1 = 1'b1;

    // 4-way select encodings.
    localparam logic [1:0] SEL4_IN0 = 2'b00;
    localparam logic [1:0] SEL4_IN1 = 2'b01;
    localparam logic [1:0] SEL4_IN2 = 2'b10;
    localparam logic [1:0] SEL4_IN3 = 2'b11;

endpackage : mux_32b_pkg
`default_nettype wire

// File: rtl/mux_2_32b.sv
`default_nettype none
// ============================================================================
// Module      : mux_2_32b
// Description : Purely combinational 2-way word multiplexer.
//               Ports (positional order is fixed, other datapath blocks
//               instantiate this module by position):
//                 out    - selected word (WIDTH)
//                 select - 1-bit select, 0 -> input0, 1 -> input1
//                 input0 - data word 0 (WIDTH)
//                 input1 - data word 1 (WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_2_32b
    import mux_32b_pkg::*;
#(
    parameter int WIDTH = mux_32b_pkg::WIDTH
) (
    output logic [WIDTH-1:0] out,
    input  logic             select,
    input  logic [WIDTH-1:0] input0,
    input  logic [WIDTH-1:0] input1
);

    // An unknown select yields an all-X word rather than silently
    // falling back to input0, so select problems stay visible.
    always_comb begin
        out = {WIDTH{1'bx}};
        case (select)
            SEL2_IN0: out = input0;
            SEL2_IN1: out = input1;
            default:  out = {WIDTH{1'bx}};
        endcase
    end

endmodule : mux_2_32b
`default_nettype wire

// File: rtl/mux_4_32b.sv
`default_nettype none
// ============================================================================
// Module      : mux_4_32b
// Description : Purely combinational 4-way word multiplexer, implemented
//               as a single-level case on select.
//               Ports (positional order is fixed):
//                 out    - selected word (WIDTH)
//                 select - 2-bit select, 00/01/10/11 -> input0..input3
//                 input0 - data word 0 (WIDTH)
//                 input1 - data word 1 (WIDTH)
//                 input2 - data word 2 (WIDTH)
//                 input3 - data word 3 (WIDTH)
// Revision    : 1.0 - initial release
// ============================================================================
module mux_4_32b
    import mux_32b_pkg::*;
#(
    parameter int WIDTH = mux_32b_pkg::WIDTH
) (
    output logic [WIDTH-1:0] out,
    input  logic [1:0]       select,
    input  logic [WIDTH-1:0] input0,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic [WIDTH-1:0] input3
);

    // Flat case (not a tree of 2-way muxes) keeps this a single mux level.
    // Any X/Z in select falls to the default and produces an all-X word.
    always_comb begin
        out = {WIDTH{1'bx}};
        case (select)
            SEL4_IN0: out = input0;
            SEL4_IN1: out = input1;
            SEL4_IN2: out = input2;
            SEL4_IN3: out = input3;
            default:  out = {WIDTH{1'bx}};
        endcase
    end

endmodule : mux_4_32b
`default_nettype wire

// File: rtl/mux_32b.sv
`default_nettype none
// ============================================================================
// Module      : mux_32b
// Description : Word-select unit for the single-cycle MIPS datapath.
//               Provides combinational 2-way and 4-way results for
//               same-cycle use and registered copies for stage boundaries.
//               Ports:
//                 clk    - clock, registers update on rising edge
//                 rst_n  - synchronous active-low reset (registered outputs)
//                 sel2   - 2-way select
//                 a0, a1 - 2-way data inputs (WIDTH)
//                 sel4   - 4-way select (2 bits)
//                 b0..b3 - 4-way data inputs (WIDTH)
//                 out2   - combinational 2-way result
//                 out4   - combinational 4-way result
//                 out2_q - out2 registered one cycle
//                 out4_q - out4 registered one cycle
// Revision    : 1.0 - initial release
// ============================================================================
module mux_32b
    import mux_32b_pkg::*;
#(
    parameter int WIDTH = mux_32b_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel2,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic [1:0]       sel4,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] b1,
    input  logic [WIDTH-1:0] b2,
    input  logic [WIDTH-1:0] b3,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out2_q,
    output logic [WIDTH-1:0] out4_q
);

    logic [WIDTH-1:0] r_out2_q;
    logic [WIDTH-1:0] r_out4_q;

    mux_2_32b #(
        .WIDTH  (WIDTH)
    ) u_mux_2 (
        .out    (out2),
        .select (sel2),
        .input0 (a0),
        .input1 (a1)
    );

    mux_4_32b #(
        .WIDTH  (WIDTH)
    ) u_mux_4 (
        .out    (out4),
        .select (sel4),
        .input0 (b0),
        .input1 (b1),
        .input2 (b2),
        .input3 (b3)
    );

    // Stage-boundary copies. Reset clears only these registers; the
    // combinational outputs are never affected by rst_n.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out2_q <= '0;
            r_out4_q <= '0;
        end else begin
            r_out2_q <= out2;
            r_out4_q <= out4;
        end
    end

    assign out2_q = r_out2_q;
    assign out4_q = r_out4_q;

endmodule : mux_32b
`default_nettype wire

// File: tb/tb_mux_32b.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_32b
// Description : Self-checking bench for mux_32b. Expected values come from
//               array-indexed reference words held in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_32b;

    logic        clk;
    logic        rst_n;
    logic        sel2;
    logic [31:0] a0, a1;
    logic [1:0]  sel4;
    logic [31:0] b0, b1, b2, b3;
    logic [31:0] out2, out4, out2_q, out4_q;

    int pass_cnt;
    int total_cnt;

    // Reference words: the selected output is simply av[sel2] / bv[sel4].
    logic [31:0] av [2];
    logic [31:0] bv [4];

    mux_32b #(
        .WIDTH  (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sel2   (sel2),
        .a0     (a0),
        .a1     (a1),
        .sel4   (sel4),
        .b0     (b0),
        .b1     (b1),
        .b2     (b2),
        .b3     (b3),
        .out2   (out2),
        .out4   (out4),
        .out2_q (out2_q),
        .out4_q (out4_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_words();
        a0 = av[0]; a1 = av[1];
        b0 = bv[0]; b1 = bv[1]; b2 = bv[2]; b3 = bv[3];
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sel2 = 1'b1; sel4 = 2'b10;
        av[0] = 32'h0101_0101; av[1] = 32'h0202_0202;
        bv[0] = 32'h1; bv[1] = 32'h2; bv[2] = 32'h3; bv[3] = 32'h4;
        drive_words();
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (out2_q !== 32'h0) $display("FAIL reset_out2_q: got %h want %h", out2_q, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (out4_q !== 32'h0) $display("FAIL reset_out4_q: got %h want %h", out4_q, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (out2 !== av[1]) $display("FAIL reset_out2_comb: got %h want %h", out2, av[1]);
        else pass_cnt++;
        total_cnt++;
        if (out4 !== bv[2]) $display("FAIL reset_out4_comb: got %h want %h", out4, bv[2]);
        else pass_cnt++;
    endtask

    task automatic test_sel2_sweep();
        logic [31:0] want [3];
        logic        seq  [3];
        want[0] = 32'h5; want[1] = 32'hA; want[2] = 32'h5;
        seq[0] = 1'b0; seq[1] = 1'b1; seq[2] = 1'b0;
        av[0] = 32'h0000_0005; av[1] = 32'h0000_000A;
        drive_words();
        for (int i = 0; i < 3; i++) begin
            sel2 = seq[i];
            #1;
            total_cnt++;
            if (out2 !== want[i]) $display("FAIL sel2_sweep[%0d]: got %h want %h", i, out2, want[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_sel4_sweep();
        logic [31:0] want [4];
        want[0] = 32'h11; want[1] = 32'h22; want[2] = 32'h33; want[3] = 32'h44;
        bv[0] = 32'h11; bv[1] = 32'h22; bv[2] = 32'h33; bv[3] = 32'h44;
        drive_words();
        for (int i = 0; i < 4; i++) begin
            sel4 = 2'(i);
            #1;
            total_cnt++;
            if (out4 !== want[i]) $display("FAIL sel4_sweep[%0d]: got %h want %h", i, out4, want[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_data_track();
        sel4 = 2'b10;
        b2 = 32'hFFFF_FFFE;
        #1;
        total_cnt++;
        if (out4 !== 32'hFFFF_FFFE) $display("FAIL track_b2_fe: got %h want %h", out4, 32'hFFFF_FFFE);
        else pass_cnt++;
        b2 = b2 + 32'h1;
        #1;
        total_cnt++;
        if (out4 !== 32'hFFFF_FFFF) $display("FAIL track_b2_ff: got %h want %h", out4, 32'hFFFF_FFFF);
        else pass_cnt++;
        b0 = 32'hAAAA_0000; b1 = 32'h5555_0000; b3 = 32'h1234_5678;
        #1;
        total_cnt++;
        if (out4 !== 32'hFFFF_FFFF) $display("FAIL track_others: got %h want %h", out4, 32'hFFFF_FFFF);
        else pass_cnt++;
    endtask

    task automatic test_passthrough();
        sel2 = 1'b1;
        a1 = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if (out2 !== 32'hDEAD_BEEF) $display("FAIL pass_deadbeef: got %h want %h", out2, 32'hDEAD_BEEF);
        else pass_cnt++;
        a1 = 32'h8000_0001;
        #1;
        total_cnt++;
        if (out2 !== 32'h8000_0001) $display("FAIL pass_80000001: got %h want %h", out2, 32'h8000_0001);
        else pass_cnt++;
    endtask

    task automatic test_registered();
        // Re-establish reset, then release and apply new inputs.
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if (out2_q !== 32'h0) $display("FAIL reg_reset_out2_q: got %h want %h", out2_q, 32'h0);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        sel2 = 1'b1;
        a1 = 32'h0000_1234;
        sel4 = 2'b01;
        b1 = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out2_q !== 32'h0000_1234) $display("FAIL reg_load_out2_q: got %h want %h", out2_q, 32'h0000_1234);
        else pass_cnt++;
        total_cnt++;
        if (out4_q !== 32'hCAFE_F00D) $display("FAIL reg_load_out4_q: got %h want %h", out4_q, 32'hCAFE_F00D);
        else pass_cnt++;
        // Mid-run reset clears only the registered copies.
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out2_q !== 32'h0) $display("FAIL midreset_out2_q: got %h want %h", out2_q, 32'h0);
        else pass_cnt++;
        total_cnt++;
        if (out2 !== 32'h0000_1234) $display("FAIL midreset_out2: got %h want %h", out2, 32'h0000_1234);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total_cnt++;
        if (out2_q !== 32'h0000_1234) $display("FAIL resume_out2_q: got %h want %h", out2_q, 32'h0000_1234);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [31:0] exp2, exp4, exp2_q, exp4_q;
        int          errs;
        errs = 0;
        for (int n = 0; n < 10000; n++) begin
            @(negedge clk);
            av[0] = $urandom; av[1] = $urandom;
            for (int k = 0; k < 4; k++) bv[k] = $urandom;
            sel2  = 1'($urandom_range(0, 1));
            sel4  = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 15) != 0);
            drive_words();
            exp2 = av[sel2];
            exp4 = bv[sel4];
            exp2_q = rst_n ? exp2 : 32'h0;
            exp4_q = rst_n ? exp4 : 32'h0;
            #1;
            total_cnt++;
            if (out2 !== exp2) begin
                errs++;
                if (errs < 10) $display("FAIL rand_out2[%0d]: got %h want %h", n, out2, exp2);
            end else pass_cnt++;
            total_cnt++;
            if (out4 !== exp4) begin
                errs++;
                if (errs < 10) $display("FAIL rand_out4[%0d]: got %h want %h", n, out4, exp4);
            end else pass_cnt++;
            @(posedge clk);
            #1;
            total_cnt++;
            if (out2_q !== exp2_q) begin
                errs++;
                if (errs < 10) $display("FAIL rand_out2_q[%0d]: got %h want %h", n, out2_q, exp2_q);
            end else pass_cnt++;
            total_cnt++;
            if (out4_q !== exp4_q) begin
                errs++;
                if (errs < 10) $display("FAIL rand_out4_q[%0d]: got %h want %h", n, out4_q, exp4_q);
            end else pass_cnt++;
        end
        rst_n = 1'b1;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n = 1'b0;
        sel2  = 1'b0;
        sel4  = 2'b00;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0; b2 = '0; b3 = '0;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        test_sel2_sweep();
        test_sel4_sweep();
        test_data_track();
        test_passthrough();
        test_registered();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_mux_32b
`default_nettype wire
